// File: rtl/mio_bus_responder.sv
// mio_bus_responder: slave end of the CPU memory/IO bus.
// Answers CPU_MIO requests with MIO_ready/rdata from a word RAM (programmable wait
// states), an LED/switch port and a reload timer that raises INT.
// Optional feature macro: BUS_ERR_EN adds the bus_err output and CTRL bit3 sticky error.
//
// state  | meaning
// IDLE   | waiting for CPU_MIO; a new request latches its decode here
// WAIT   | RAM wait states counting down; CPU_MIO low aborts without ack
// ACK    | MIO_ready high for one cycle, rdata valid, write commits on the edge

module mio_bus_responder #(
  parameter int RAM_AW   = 10,
  parameter int RAM_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CPU_MIO,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        MIO_ready,
  output logic        INT,
  input  logic [7:0]  sw_in,
  output logic [7:0]  led_out
`ifdef BUS_ERR_EN
  ,
  output logic        bus_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
  typedef enum logic [1:0] {K_RAM, K_IO, K_UNM} kind_t;

  localparam int         IDX_HI    = RAM_AW + 1;
  localparam logic [3:0] WAIT_INIT = 4'(RAM_WAIT > 0 ? RAM_WAIT - 1 : 0);

  state_t            state;
  logic [3:0]        wait_cnt;
  kind_t             req_kind;
  logic              req_we;
  logic [RAM_AW-1:0] req_idx;
  logic [1:0]        req_off;
  logic [31:0]       req_wdata;

  logic [31:0]       ram [2**RAM_AW];

  logic [31:0]       reload;
  logic [31:0]       tmr_cnt;
  logic              tmr_en;
  logic              irq_en;
  logic              pending;
  logic              err_sticky;

  kind_t             dec_kind;
  kind_t             acc_kind;
  logic [RAM_AW-1:0] acc_idx;
  logic [1:0]        acc_off;
  logic [31:0]       rd_val;
  logic              io_wr;
  logic              ctrl_wr;
  logic              expire;
  logic              unused_addr;

  // Decode the live request address into RAM / IO / unmapped
  always_comb begin
    dec_kind = K_UNM;
    if (addr[31:RAM_AW+2] == '0)
      dec_kind = K_RAM;
    else if (addr[31:28] == 4'hF)
      dec_kind = K_IO;
  end

  // Access being answered: live request when leaving IDLE, latched one from WAIT
  always_comb begin
    acc_kind = req_kind;
    acc_idx  = req_idx;
    acc_off  = req_off;
    if (state == S_IDLE) begin
      acc_kind = dec_kind;
      acc_idx  = addr[IDX_HI:2];
      acc_off  = addr[3:2];
    end
  end

  // Read mux; sampled into rdata on the edge that enters ACK
  always_comb begin
    rd_val = '0;
    case (acc_kind)
      K_RAM: rd_val = ram[acc_idx];
      K_IO: begin
        case (acc_off)
          2'd0:    rd_val = {24'b0, led_out};
          2'd1:    rd_val = {24'b0, sw_in};
          2'd2:    rd_val = reload;
          default: rd_val = {28'b0, err_sticky, pending, irq_en, tmr_en};
        endcase
      end
      default: rd_val = '0;
    endcase
  end

  assign io_wr       = (state == S_ACK) && req_we && (req_kind == K_IO);
  assign ctrl_wr     = io_wr && (req_off == 2'd3);
  assign expire      = tmr_en && (tmr_cnt == '0);
  assign INT         = pending & irq_en;
  assign unused_addr = ^addr[1:0];

  // Bus handshake FSM with registered MIO_ready/rdata
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      MIO_ready <= 1'b0;
      rdata     <= '0;
      req_kind  <= K_UNM;
      req_we    <= 1'b0;
      req_idx   <= '0;
      req_off   <= '0;
      req_wdata <= '0;
`ifdef BUS_ERR_EN
      bus_err   <= 1'b0;
`endif
    end else begin
      MIO_ready <= 1'b0;
      rdata     <= '0;
`ifdef BUS_ERR_EN
      bus_err   <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (CPU_MIO) begin
            req_kind  <= dec_kind;
            req_we    <= mem_w;
            req_idx   <= addr[IDX_HI:2];
            req_off   <= addr[3:2];
            req_wdata <= wdata;
            if (dec_kind == K_RAM && RAM_WAIT > 0) begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_INIT;
            end else begin
              state     <= S_ACK;
              MIO_ready <= 1'b1;
              rdata     <= rd_val;
`ifdef BUS_ERR_EN
              bus_err   <= (dec_kind == K_UNM);
`endif
            end
          end
        end
        S_WAIT: begin
          // abort has priority over a wait count that just ran out
          if (!CPU_MIO) begin
            state <= S_IDLE;
          end else if (wait_cnt == '0) begin
            state     <= S_ACK;
            MIO_ready <= 1'b1;
            rdata     <= rd_val;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (!reset && state == S_ACK && req_we && req_kind == K_RAM)
      ram[req_idx] <= req_wdata;
  end

  // IO register writes and the reload timer; an expiry beats a pending clear
  always_ff @(posedge clk) begin
    if (reset) begin
      led_out <= '0;
      reload  <= '0;
      tmr_cnt <= '0;
      tmr_en  <= 1'b0;
      irq_en  <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (tmr_en)
        tmr_cnt <= expire ? reload : tmr_cnt - 32'd1;
      if (expire)
        pending <= 1'b1;
      else if (ctrl_wr && req_wdata[2])
        pending <= 1'b0;
      if (io_wr && req_off == 2'd0)
        led_out <= req_wdata[7:0];
      if (io_wr && req_off == 2'd2)
        reload <= req_wdata;
      if (ctrl_wr) begin
        tmr_en <= req_wdata[0];
        irq_en <= req_wdata[1];
        if (req_wdata[0] && !tmr_en)
          tmr_cnt <= reload;
      end
    end
  end

`ifdef BUS_ERR_EN
  // Sticky error: set by an unmapped access, cleared by writing 1 to CTRL bit3
  always_ff @(posedge clk) begin
    if (reset)
      err_sticky <= 1'b0;
    else if (state == S_ACK && req_kind == K_UNM)
      err_sticky <= 1'b1;
    else if (ctrl_wr && req_wdata[3])
      err_sticky <= 1'b0;
  end
`else
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_mio_bus_responder.sv
// Self-checking bench for mio_bus_responder: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the bus, register map and timer.
module tb_mio_bus_responder;
  localparam int RAM_AW   = 10;
  localparam int RAM_WAIT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        CPU_MIO = 1'b0;
  logic        mem_w = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        MIO_ready;
  logic        INT;
  logic [7:0]  sw_in = '0;
  logic [7:0]  led_out;
`ifdef BUS_ERR_EN
  logic        bus_err;
`endif

  always #5 clk = ~clk;

  mio_bus_responder #(.RAM_AW(RAM_AW), .RAM_WAIT(RAM_WAIT)) dut (
    .clk(clk), .reset(reset), .CPU_MIO(CPU_MIO), .mem_w(mem_w), .addr(addr),
    .wdata(wdata), .rdata(rdata), .MIO_ready(MIO_ready), .INT(INT),
    .sw_in(sw_in), .led_out(led_out)
`ifdef BUS_ERR_EN
    , .bus_err(bus_err)
`endif
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int ack_cyc = 0;
  logic last_err = 1'b0;
  bit chk_on = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // ---------------- reference model ----------------
  typedef enum {R_RAM, R_IO, R_UNM} region_t;

  logic [31:0] m_ram [int];
  logic [7:0]  m_led;
  logic [31:0] m_reload, m_cnt;
  bit          m_en, m_irq, m_pend, m_sticky;
  bit          m_busy;
  int          m_due;
  region_t     q_reg;
  bit          q_we;
  logic [31:0] q_addr, q_wdata;
  bit          e_ready, e_rvalid, e_err;
  logic [31:0] e_rdata;

  function automatic region_t region_of(input logic [31:0] a);
    if (a[31:28] == 4'hF) return R_IO;
    if (a < (32'h1 << (RAM_AW + 2))) return R_RAM;
    return R_UNM;
  endfunction

  function automatic void model_read(output logic [31:0] v, output bit ok);
    int w;
    w = int'(q_addr >> 2);
    ok = !q_we;
    v = '0;
    case (q_reg)
      R_RAM: if (m_ram.exists(w)) v = m_ram[w]; else ok = 1'b0;
      R_IO: begin
        case (q_addr[3:2])
          2'd0: v = {24'b0, m_led};
          2'd1: v = {24'b0, sw_in};
          2'd2: v = m_reload;
          default: begin
`ifdef BUS_ERR_EN
            v = {28'b0, m_sticky, m_pend, m_irq, m_en};
`else
            v = {29'b0, m_pend, m_irq, m_en};
`endif
          end
        endcase
      end
      default: v = '0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    bit          expire, n_pend, n_ready, n_err;
    logic [31:0] n_cnt;
    int          lat;
    cyc++;
    if (reset) begin
      m_led = '0; m_reload = '0; m_cnt = '0;
      m_en = 0; m_irq = 0; m_pend = 0; m_sticky = 0;
      m_busy = 0; e_ready = 0; e_err = 0; e_rvalid = 1; e_rdata = '0;
    end else begin
      expire  = m_en && (m_cnt == 0);
      n_cnt   = !m_en ? m_cnt : (m_cnt == 0 ? m_reload : m_cnt - 1);
      n_pend  = m_pend || expire;
      n_ready = 0;
      n_err   = 0;
      if (e_ready) begin
        m_busy = 0;
        if (q_reg == R_UNM) m_sticky = 1;
        else if (q_we && q_reg == R_RAM) m_ram[int'(q_addr >> 2)] = q_wdata;
        else if (q_we) begin
          case (q_addr[3:2])
            2'd0: m_led = q_wdata[7:0];
            2'd2: m_reload = q_wdata;
            2'd3: begin
              if (q_wdata[0] && !m_en) n_cnt = m_reload;
              m_en  = q_wdata[0];
              m_irq = q_wdata[1];
              if (q_wdata[2] && !expire) n_pend = 0;
              if (q_wdata[3]) m_sticky = 0;
            end
            default: ;
          endcase
        end
      end else begin
        if (!m_busy && CPU_MIO) begin
          q_reg = region_of(addr); q_we = mem_w; q_addr = addr; q_wdata = wdata;
          m_busy = 1;
          lat = (q_reg == R_RAM) ? RAM_WAIT + 1 : 1;
          m_due = cyc + lat - 1;
        end else if (m_busy && !CPU_MIO) begin
          m_busy = 0;
        end
        if (m_busy && cyc == m_due) begin
          n_ready = 1;
          n_err = (q_reg == R_UNM);
          model_read(e_rdata, e_rvalid);
        end
      end
      m_cnt = n_cnt; m_pend = n_pend; e_ready = n_ready; e_err = n_err;
    end
  end

  // Compare process: DUT outputs against the model every cycle
  always @(negedge clk) begin
    if (chk_on) begin
      chk("ready", 32'(MIO_ready), 32'(e_ready));
      chk("int", 32'(INT), 32'(m_irq & m_pend));
      chk("led", 32'(led_out), 32'(m_led));
      if (e_ready && e_rvalid) chk("rdata", rdata, e_rdata);
`ifdef BUS_ERR_EN
      chk("bus_err", 32'(bus_err), 32'(e_err));
`endif
    end
  end

  // ---------------- stimulus ----------------
  // Called just after a posedge with the DUT idle; returns just after the ack's commit edge.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input bit keep, output logic [31:0] rd, output int lat);
    CPU_MIO = 1'b1; mem_w = w; addr = a; wdata = d; lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!MIO_ready && lat < 64);
    chk("ack_seen", 32'(MIO_ready), 32'd1);
    rd = rdata;
    ack_cyc = cyc;
`ifdef BUS_ERR_EN
    last_err = bus_err;
`endif
    @(posedge clk); #1;
    if (!keep) CPU_MIO = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, a, d;
    int lat, n, a1, k;
    bit seen, w;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_on = 1'b1;
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ready", 32'(MIO_ready), 32'd0);
    chk("rst_int", 32'(INT), 32'd0);
    chk("rst_led", 32'(led_out), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // RAM write/read with wait states
    bus(1, 32'h0000_0010, 32'hDEAD_BEEF, 0, rd, lat);
    chk("t1_wr_lat", lat, 32'd3);
    bus(0, 32'h0000_0010, 32'h0, 0, rd, lat);
    chk("t1_rd_lat", lat, 32'd3);
    chk("t1_rd_data", rd, 32'hDEAD_BEEF);

    // LED write, switch read
    bus(1, 32'hF000_0000, 32'h0000_00A5, 0, rd, lat);
    chk("t2_wr_lat", lat, 32'd1);
    chk("t2_led", 32'(led_out), 32'hA5);
    sw_in = 8'h3C;
    bus(0, 32'hF000_0004, 32'h0, 0, rd, lat);
    chk("t2_rd_lat", lat, 32'd1);
    chk("t2_sw", rd, 32'h0000_003C);

    // Timer: RELOAD=3, enable with irq
    bus(1, 32'hF000_0008, 32'd3, 0, rd, lat);
    bus(1, 32'hF000_000C, 32'd3, 0, rd, lat);
    n = 0;
    while (!INT && n < 20) begin @(posedge clk); #1; n++; end
    chk("t3_first_int", n, 32'd4);
    bus(1, 32'hF000_000C, 32'd7, 0, rd, lat);
    chk("t3_clear", 32'(INT), 32'd0);
    n = 0;
    while (!INT && n < 20) begin @(posedge clk); #1; n++; end
    chk("t3_period", n, 32'd2);
    bus(1, 32'hF000_0008, 32'd0, 0, rd, lat);
    repeat (4) begin @(posedge clk); #1; end
    bus(1, 32'hF000_000C, 32'd7, 0, rd, lat);
    chk("t3_set_wins", 32'(INT), 32'd1);
    bus(1, 32'hF000_000C, 32'd0, 0, rd, lat);
    bus(1, 32'hF000_000C, 32'd6, 0, rd, lat);
    chk("t3_int_clr", 32'(INT), 32'd0);

    // Abort a RAM write in WAIT
    CPU_MIO = 1; mem_w = 1; addr = 32'h0000_0010; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    CPU_MIO = 0;
    seen = 0;
    repeat (5) begin @(negedge clk); if (MIO_ready) seen = 1; end
    chk("t4_no_ack", 32'(seen), 32'd0);
    @(posedge clk); #1;
    bus(0, 32'h0000_0010, 32'h0, 0, rd, lat);
    chk("t4_old_data", rd, 32'hDEAD_BEEF);

    // Reset mid-WAIT
    CPU_MIO = 1; mem_w = 0; addr = 32'h0000_0010;
    @(posedge clk); #1;
    reset = 1; CPU_MIO = 0;
    @(posedge clk); #1;
    chk("t4_rst_ready", 32'(MIO_ready), 32'd0);
    chk("t4_rst_rdata", rdata, 32'd0);
    chk("t4_rst_led", 32'(led_out), 32'd0);
    chk("t4_rst_int", 32'(INT), 32'd0);
    reset = 0;
    repeat (4) begin @(posedge clk); #1; end

    // Unmapped read
    bus(0, 32'h8000_0000, 32'h0, 0, rd, lat);
    chk("t5_lat", lat, 32'd1);
    chk("t5_rdata", rd, 32'd0);
`ifdef BUS_ERR_EN
    chk("t5_bus_err", 32'(last_err), 32'd1);
    bus(0, 32'hF000_000C, 32'h0, 0, rd, lat);
    chk("t5_ctrl", rd, 32'h8);
    bus(1, 32'hF000_000C, 32'h8, 0, rd, lat);
`else
    bus(0, 32'hF000_000C, 32'h0, 0, rd, lat);
    chk("t5_ctrl", rd, 32'h0);
`endif

    // Back-to-back IO reads
    bus(0, 32'hF000_0004, 32'h0, 1, rd, lat);
    a1 = ack_cyc;
    bus(0, 32'hF000_0008, 32'h0, 0, rd, lat);
    chk("t6_gap", ack_cyc - a1, 32'd2);
    chk("t6_lat", lat, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      if ($urandom_range(0, 7) == 0) sw_in = 8'($urandom);
      k = $urandom_range(0, 9);
      w = 1'($urandom);
      d = $urandom;
      a = $urandom;
      case (k)
        0, 1, 2, 3, 9: a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        4, 5, 6, 7: begin
          a[31:28] = 4'hF;
          if (a[3:2] == 2'd3) d = $urandom_range(0, 15);
          if (a[3:2] == 2'd2) d = $urandom_range(0, 6);
        end
        default: begin
          if (a[31:28] == 4'hF) a[31:28] = 4'h8;
          if (a < 32'h1000) a[20] = 1'b1;
        end
      endcase
      if (k == 9) begin
        CPU_MIO = 1; mem_w = w; addr = a; wdata = d;
        @(posedge clk); #1;
        CPU_MIO = 0;
        @(posedge clk); #1;
      end else begin
        bus(w, a, d, 0, rd, lat);
      end
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
